// File: rtl/hartslag_meet_sched_if.sv
// Scheduler bus: run control, raw sensor pulses and result/status outputs.
// master: drives enable, ch_mask, sensor_in; observes results and status.
// slave : the scheduler side.
interface hartslag_meet_sched_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned OUT_W = 4
);
  logic             enable;
  logic [N_CH-1:0]  ch_mask;
  logic [N_CH-1:0]  sensor_in;
  logic             result_valid;
  logic [CH_W-1:0]  result_ch;
  logic [OUT_W-1:0] result_data;
  logic             result_timeout;
  logic [CH_W-1:0]  cur_ch;
  logic             busy;

  modport master (
    output enable, ch_mask, sensor_in,
    input  result_valid, result_ch, result_data, result_timeout, cur_ch, busy
  );

  modport slave (
    input  enable, ch_mask, sensor_in,
    output result_valid, result_ch, result_data, result_timeout, cur_ch, busy
  );
endinterface

// File: rtl/hartslag_meet_sched.sv
// Shared period-measurement scheduler for up to N_CH pulse sensors.
// Channels are visited round-robin; each visit arms on a rising edge and
// counts clk cycles to the next rising edge, then reports the upper OUT_W
// bits of the period (or a timeout when the counter reaches all-ones).
// Ports: clk, reset (async, active-high), bus (hartslag_meet_sched_if.slave):
//   enable, ch_mask, sensor_in in; result_valid/ch/data/timeout, cur_ch, busy out.
// Optional: define HARTSLAG_AVG2_EN to report the average of the current and
// previous period per channel.
module hartslag_meet_sched #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 25,
  parameter int unsigned OUT_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  hartslag_meet_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ARM, S_MEASURE, S_REPORT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic [OUT_W-1:0] result_data_q, result_data_d;
  logic             result_valid_q, result_valid_d;
  logic             result_timeout_q, result_timeout_d;
  logic             busy_q, busy_d;
  logic [N_CH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;

  logic [N_CH-1:0]  rise_c;
  logic             cur_rise_c;
  logic             pick_found_c;
  logic [CH_W-1:0]  pick_ch_c, pick_idx_c;
  logic [CNT_W-1:0] period_c;
  logic [OUT_W-1:0] code_c;
  logic             rep_ok_c, rep_to_c;

`ifdef HARTSLAG_AVG2_EN
  logic [CNT_W-1:0] prev_q [N_CH];
  logic [CNT_W-1:0] prev_d [N_CH];
  logic [N_CH-1:0]  pvld_q, pvld_d;
`endif

  // Synchronised rising edge per channel; same latency on every channel.
  assign rise_c     = sync2_q & ~dly_q;
  assign cur_rise_c = rise_c[cur_ch_q];
  assign period_c   = cnt_q + CNT_W'(1);

  // First mask bit strictly after the round-robin pointer, wrapping.
  always_comb begin
    pick_found_c = 1'b0;
    pick_ch_c    = rr_q;
    pick_idx_c   = rr_q;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      pick_idx_c = CH_W'((32'(rr_q) + i) % N_CH);
      if (!pick_found_c && bus.ch_mask[pick_idx_c]) begin
        pick_found_c = 1'b1;
        pick_ch_c    = pick_idx_c;
      end
    end
  end

  // Reported code; the averaged form keeps the carry in CNT_W+1 bits.
`ifdef HARTSLAG_AVG2_EN
  always_comb begin
    if (pvld_q[cur_ch_q]) begin
      code_c = OUT_W'(({1'b0, period_c} + {1'b0, prev_q[cur_ch_q]}) >> (CNT_W + 1 - OUT_W));
    end else begin
      code_c = OUT_W'(period_c >> (CNT_W - OUT_W));
    end
  end
`else
  assign code_c = OUT_W'(period_c >> (CNT_W - OUT_W));
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rr_d             = rr_q;
    cur_ch_d         = cur_ch_q;
    result_valid_d   = 1'b0;
    result_ch_d      = result_ch_q;
    result_data_d    = result_data_q;
    result_timeout_d = result_timeout_q;
    sync1_d          = bus.sensor_in;
    sync2_d          = sync1_q;
    dly_d            = sync2_q;
    rep_ok_c         = 1'b0;
    rep_to_c         = 1'b0;
`ifdef HARTSLAG_AVG2_EN
    prev_d           = prev_q;
    pvld_d           = pvld_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && (|bus.ch_mask)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (pick_found_c) begin
          rr_d     = pick_ch_c;
          cur_ch_d = pick_ch_c;
          cnt_d    = '0;
          state_d  = S_ARM;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ARM: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (cur_rise_c) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end else begin
          cnt_d = period_c;
          if (period_c == CNT_TOP) rep_to_c = 1'b1;
        end
      end
      S_MEASURE: begin
        // Edge takes priority over a simultaneous timeout.
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (cur_rise_c) begin
          rep_ok_c = 1'b1;
        end else begin
          cnt_d = period_c;
          if (period_c == CNT_TOP) rep_to_c = 1'b1;
        end
      end
      S_REPORT: begin
        state_d = bus.enable ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result fields are loaded on entry so the strobe lines up with REPORT.
    if (rep_ok_c || rep_to_c) begin
      state_d          = S_REPORT;
      result_valid_d   = 1'b1;
      result_ch_d      = cur_ch_q;
      result_timeout_d = rep_to_c;
      result_data_d    = rep_to_c ? '0 : code_c;
`ifdef HARTSLAG_AVG2_EN
      if (rep_ok_c) prev_d[cur_ch_q] = period_c;
      pvld_d[cur_ch_q] = rep_ok_c;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      rr_q             <= CH_W'(N_CH - 1);
      cur_ch_q         <= '0;
      result_valid_q   <= 1'b0;
      result_ch_q      <= '0;
      result_data_q    <= '0;
      result_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
      sync1_q          <= '0;
      sync2_q          <= '0;
      dly_q            <= '0;
`ifdef HARTSLAG_AVG2_EN
      for (int unsigned i = 0; i < N_CH; i++) prev_q[i] <= '0;
      pvld_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rr_q             <= rr_d;
      cur_ch_q         <= cur_ch_d;
      result_valid_q   <= result_valid_d;
      result_ch_q      <= result_ch_d;
      result_data_q    <= result_data_d;
      result_timeout_q <= result_timeout_d;
      busy_q           <= busy_d;
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      dly_q            <= dly_d;
`ifdef HARTSLAG_AVG2_EN
      prev_q           <= prev_d;
      pvld_q           <= pvld_d;
`endif
    end
  end

  assign bus.result_valid   = result_valid_q;
  assign bus.result_ch      = result_ch_q;
  assign bus.result_data    = result_data_q;
  assign bus.result_timeout = result_timeout_q;
  assign bus.cur_ch         = cur_ch_q;
  assign bus.busy           = busy_q;

endmodule

// File: doc/hartslag_meet_sched.md
Name: hartslag_meet_sched

Overview:
- Measurement scheduler that shares one period-measurement counter between up to N_CH pulse sensors (heartbeat, breathing, rocking-motion pickups).
- Selects enabled channels round-robin, arms on a rising edge, and counts clk cycles to the next rising edge.
- Reports a coarse period code (upper OUT_W bits of the count), or a timeout.
- Sits between the raw sensor inputs and the display/rocking-decision logic; replaces one dedicated counter per sensor.

Parameters:
- N_CH, 4, number of sensor channels (2..2^CH_W).
- CH_W, 2, width of channel index.
- CNT_W, 25, period counter width; timeout at all-ones.
- OUT_W, 4, reported code width; code = P[CNT_W-1 -: OUT_W].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scheduler run enable.
- ch_mask  in  N_CH  channel enable mask; sampled only in SELECT.
- sensor_in  in  N_CH  asynchronous sensor pulse inputs.
- result_valid  out  1  one-cycle strobe, result fields updated.
- result_ch  out  CH_W  channel of latest result.
- result_data  out  OUT_W  period code of latest result.
- result_timeout  out  1  latest result was a timeout.
- cur_ch  out  CH_W  channel currently selected.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; round-robin pointer = N_CH-1, so channel 0 is picked first; counter 0; state IDLE.
- Input path: per channel, 2-flop synchronizer plus one delay flop. edge = sync & ~delay.
- Edge-detect latency: an edge is detected 3 clk after the input rises. This latency is identical on every channel, so periods are unaffected.
- States: IDLE, SELECT, ARM, MEASURE, REPORT.
- IDLE: if enable=1 and ch_mask!=0, go to SELECT next cycle.
- SELECT (1 cycle):
  - Pick the first set ch_mask bit strictly after the pointer, wrapping modulo N_CH.
  - Load the pointer and cur_ch with the picked channel.
  - Clear the counter; go to ARM.
  - If ch_mask reads 0 here, go to IDLE.
- ARM:
  - Counter increments each cycle.
  - edge on cur_ch: counter := 0, go to MEASURE.
  - Otherwise, counter reaching all-ones: go to REPORT with timeout.
- MEASURE:
  - Counter increments each cycle.
  - edge on cur_ch: P = number of clk cycles between the arming edge and this edge (counter+1); go to REPORT.
  - Otherwise, counter reaching all-ones: go to REPORT with timeout.
  - Edge and timeout in the same cycle: the edge wins.
- REPORT (1 cycle):
  - result_valid=1.
  - result_ch := cur_ch.
  - result_timeout := timeout flag.
  - result_data := 0 on timeout, else P[CNT_W-1 -: OUT_W].
  - Next state: SELECT if enable=1, else IDLE.
- Result fields hold their value between strobes.
- enable falling in ARM or MEASURE: abort to IDLE next cycle with no report; the pointer keeps its value.
- Edges on unselected channels are ignored and not queued.
- Clearing the cur_ch mask bit mid-measurement has no effect until the next SELECT.
- Asynchronous reset mid-operation: immediate return to reset values, no strobe.

Optional Feature:
- Macro: HARTSLAG_AVG2_EN.
- When defined:
  - Per-channel register prev[CNT_W] plus a valid bit, both reset to 0.
  - Non-timeout report with valid bit set: code is taken from (P + prev) >> 1, computed in CNT_W+1 bits, then sliced.
  - Non-timeout report with valid bit clear: code is taken from P alone.
  - After every non-timeout report: prev := P and valid := 1.
  - A timeout clears valid for that channel.
- When undefined: no per-channel storage; code is taken from P directly.

Test Plan:
All scenarios use CNT_W=8, OUT_W=4, N_CH=4.
- Single channel: mask=0001, sensor_in[0] rising every 100 clk → result_valid strobes with result_ch=0, result_data=6 (100=0x64), result_timeout=0.
- Round-robin: mask=1011, all channels pulsing every 64 clk → result_ch sequence 0,1,3,0,1,3, each with result_data=4.
- Timeout: mask=0100, sensor_in[2] held low → result_ch=2, result_timeout=1, result_data=0, repeating every 257 clk (SELECT + 255 counts + REPORT).
- Abort: drop enable mid-MEASURE on channel 0 → busy=0 after 1 clk, no result_valid; re-enable → next pick is channel 1 (mask=0011).
- Async reset: assert reset during MEASURE → all outputs 0 immediately; after release the first pick is channel 0.
- HARTSLAG_AVG2_EN, channel 0: period 100 then 140 → codes 6, then 7 ((100+140)/2=120=0x78).
